// File: rtl/pkt_meta_align_if.sv
// rtl/pkt_meta_align_if.sv - AXI-stream style bundle shared by ingress and egress ports
// The master drives the payload and tvalid/tlast, the slave drives tready.
interface pkt_meta_align_if #(
   parameter int TDATA_NUM_BYTES = 64
) ();
   logic [TDATA_NUM_BYTES*8-1:0] tdata;
   logic [TDATA_NUM_BYTES-1:0]   tkeep;
   logic                         tvalid;
   logic                         tlast;
   logic                         tready;

   modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pkt_meta_align.sv
// rtl/pkt_meta_align.sv - pairs queued per-packet metadata with a registered AXI-stream packet
// Statistics counters exist only when PKT_META_ALIGN_STATS_EN is defined.
module pkt_meta_align #(
   parameter int TDATA_NUM_BYTES      = 64,
   parameter int USER_META_DATA_WIDTH = 9,
   parameter int META_FIFO_DEPTH      = 4
) (
   input  logic                            s_axis_aclk,
   input  logic                            s_axis_aresetn,
   pkt_meta_align_if.slave                 s_axis,
   pkt_meta_align_if.master                m_axis,
   input  logic [USER_META_DATA_WIDTH-1:0] user_metadata_in,
   input  logic                            user_metadata_in_valid,
   output logic [USER_META_DATA_WIDTH-1:0] user_metadata_out,
   output logic                            user_metadata_out_valid,
   output logic                            meta_overflow,
   output logic [31:0]                     pkt_count,
   output logic [15:0]                     meta_drop_count
);
   localparam int AW = $clog2(META_FIFO_DEPTH);
   localparam int DW = TDATA_NUM_BYTES * 8;

   typedef enum logic {IDLE, PKT} state_t;
   state_t state, state_nxt;

   logic [USER_META_DATA_WIDTH-1:0] meta_mem [META_FIFO_DEPTH];
   logic [AW:0]                     wr_ptr, rd_ptr;
   logic                            fifo_empty, fifo_full;
   logic                            egress_free, ready, accept, pop, push, drop;
   logic [DW-1:0]                   tdata_q;
   logic [TDATA_NUM_BYTES-1:0]      tkeep_q;
   logic                            tvalid_q, tlast_q;

   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign egress_free = !tvalid_q || m_axis.tready;
   assign accept      = s_axis.tvalid && ready;
   assign pop         = accept && s_axis.tlast;
   // A pop in the same cycle frees the slot, so a push while full is still taken.
   assign push        = user_metadata_in_valid && (!fifo_full || pop);
   assign drop        = user_metadata_in_valid && fifo_full && !pop;

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) state <= IDLE;
      else                 state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (accept) state_nxt = s_axis.tlast ? IDLE : PKT;
   end

   always_comb begin
      ready = egress_free && ((state == PKT) || !fifo_empty);
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge s_axis_aclk) begin
      if (push) meta_mem[wr_ptr[AW-1:0]] <= user_metadata_in;
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tdata_q  <= '0;
         tkeep_q  <= '0;
      end else if (egress_free) begin
         tvalid_q <= accept;
         if (accept) begin
            tdata_q <= s_axis.tdata;
            tkeep_q <= s_axis.tkeep;
            tlast_q <= s_axis.tlast;
         end
      end
   end

   // Head is read before any same-cycle overwrite of its slot lands.
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         user_metadata_out <= '0;
         meta_overflow     <= 1'b0;
      end else begin
         if (pop)  user_metadata_out <= meta_mem[rd_ptr[AW-1:0]];
         if (drop) meta_overflow     <= 1'b1;
      end
   end

   assign user_metadata_out_valid = tvalid_q && m_axis.tready && tlast_q;
   assign s_axis.tready = ready;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tkeep  = tkeep_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tlast  = tlast_q;

`ifdef PKT_META_ALIGN_STATS_EN
   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         pkt_count       <= '0;
         meta_drop_count <= '0;
      end else begin
         if (user_metadata_out_valid) pkt_count <= pkt_count + 32'd1;
         if (drop && (meta_drop_count != 16'hFFFF)) meta_drop_count <= meta_drop_count + 16'd1;
      end
   end
`else
   assign pkt_count       = 32'd0;
   assign meta_drop_count = 16'd0;
`endif
endmodule
